shiftreg_arb_ctrl: RTL and testbench

- Sequencer and arbiter for the N-bit serial-in shift register (`shiftreg`, ports EN, in, CLK, Q).
- Two requesters each present a parallel word. The controller grants one requester round-robin, serialises the word MSB-first into the shift register over N enabled cycles, then reads back Q.
- The read-back word is returned with a done pulse tagged with the owning requester.
- Sits between requester logic and a single shared shift-register instance.

---
 rtl/shiftreg_arb_ctrl.sv | 127 ++++++++++++
 tb/tb_shiftreg_arb_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_arb_ctrl.sv
// Round-robin arbiter and sequencer for one shared N-bit serial-in shift register.
// Streams the granted word MSB-first, then returns the word read back from Q with a tagged done pulse.
module shiftreg_arb_ctrl #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ0,
  input  logic [N-1:0] DATA0,
  input  logic         REQ1,
  input  logic [N-1:0] DATA1,
  output logic         GNT0,
  output logic         GNT1,
  output logic         SR_EN,
  output logic         SR_IN,
  input  logic [N-1:0] SR_Q,
  output logic         BUSY,
  output logic         DONE,
  output logic         DONE_ID,
  output logic [N-1:0] RESULT
);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [N-1:0]   buffer, buffer_n;
  logic           last, last_n;
  logic           owner, owner_n;
  logic           gnt0_n, gnt1_n, sr_en_n, sr_in_n, busy_n, done_n, done_id_n;
  logic [N-1:0]   result_n;
  logic           win;
  logic [N-1:0]   word;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    buffer_n  = buffer;
    last_n    = last;
    owner_n   = owner;
    gnt0_n    = 1'b0;
    gnt1_n    = 1'b0;
    sr_en_n   = SR_EN;
    sr_in_n   = SR_IN;
    busy_n    = BUSY;
    done_n    = 1'b0;
    done_id_n = DONE_ID;
    result_n  = RESULT;
    win       = (REQ0 && REQ1) ? ~last : REQ1;
    word      = win ? DATA1 : DATA0;

    unique case (state)
      IDLE: begin
        sr_en_n = 1'b0;
        sr_in_n = 1'b0;
        if (REQ0 || REQ1) begin
          buffer_n = word;
          last_n   = win;
          owner_n  = win;
          gnt0_n   = ~win;
          gnt1_n   = win;
          busy_n   = 1'b1;
          sr_en_n  = 1'b1;
          sr_in_n  = word[N-1];
          cnt_n    = '0;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(N - 1)) begin
          sr_en_n = 1'b0;
          sr_in_n = 1'b0;
          state_n = CAPTURE;
        end else begin
          // The buffer is consumed by shifting left, so the next bit is always at N-2.
          cnt_n    = cnt + 1'b1;
          sr_in_n  = buffer[N-2];
          buffer_n = {buffer[N-2:0], 1'b0};
        end
      end
      CAPTURE: begin
        result_n  = SR_Q;
        done_n    = 1'b1;
        done_id_n = owner;
        busy_n    = 1'b0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      buffer  <= '0;
      last    <= 1'b1;
      owner   <= 1'b0;
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      SR_EN   <= 1'b0;
      SR_IN   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      DONE_ID <= 1'b0;
      RESULT  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      buffer  <= buffer_n;
      last    <= last_n;
      owner   <= owner_n;
      GNT0    <= gnt0_n;
      GNT1    <= gnt1_n;
      SR_EN   <= sr_en_n;
      SR_IN   <= sr_in_n;
      BUSY    <= busy_n;
      DONE    <= done_n;
      DONE_ID <= done_id_n;
      RESULT  <= result_n;
    end
  end

endmodule

// File: tb/tb_shiftreg_arb_ctrl.sv
// Bench for shiftreg_arb_ctrl: behavioural shift register plus a transaction-level round-robin model.
// Outputs are sampled on the falling clock edge.
module tb_shiftreg_arb_ctrl;
  localparam int N  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [N-1:0] data0, data1;
  logic         gnt0, gnt1, sr_en, sr_in, busy, done, done_id;
  logic [N-1:0] sr_q, result;

  int vectors     = 0;
  int miscompares = 0;
  bit last_m      = 1'b1;
  bit mon_en      = 1'b0;

  shiftreg_arb_ctrl #(.N(N), .CW(CW)) dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .DATA0(data0), .REQ1(req1), .DATA1(data1),
    .GNT0(gnt0), .GNT1(gnt1), .SR_EN(sr_en), .SR_IN(sr_in), .SR_Q(sr_q),
    .BUSY(busy), .DONE(done), .DONE_ID(done_id), .RESULT(result)
  );

  always #5 clk = ~clk;

  initial sr_q = '0;
  always @(posedge clk) if (sr_en) sr_q <= {sr_q[N-2:0], sr_in};

  // Cross-cutting rules checked every cycle once the design has been reset.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      vectors++;
      if ((gnt0 && gnt1) || ((gnt0 || gnt1) && done)) begin
        miscompares++;
        $display("FAIL invariant t=%0t got gnt0=%b gnt1=%b done=%b want no double grant and no grant with done",
                 $time, gnt0, gnt1, done);
      end
    end
  end

  // Round-robin rule: contention goes to the requester that did not win last.
  function automatic bit pick(input bit r0, input bit r1);
    return (r0 && r1) ? !last_m : r1;
  endfunction

  task automatic wait_grant(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(gnt0 || gnt1) && cycles < 30);
    vectors++;
    if (!(gnt0 || gnt1)) begin
      miscompares++;
      $display("FAIL grant_timeout got no grant within %0d cycles want a grant", cycles);
    end
  endtask

  // Called at the sample point right after the grant edge; follows the transfer through DONE.
  task automatic follow_xfer(input bit id, input logic [N-1:0] word, input bit late);
    logic [5:0] exp_v;
    exp_v = {!id, id, 1'b1, 1'b1, word[N-1], 1'b0};
    vectors++;
    if ({gnt0, gnt1, busy, sr_en, sr_in, done} !== exp_v) begin
      miscompares++;
      $display("FAIL grant_cycle got g0,g1,busy,en,in,done=%b want %b", {gnt0, gnt1, busy, sr_en, sr_in, done}, exp_v);
    end
    for (int i = 1; i < N; i++) begin
      if (late && i == 1) req0 = 1'b1;
      if (late && i == 2) begin
        req0 = 1'b0;
        req1 = 1'b1;
      end
      @(negedge clk);
      exp_v = {2'b00, 1'b1, 1'b1, word[N-1-i], 1'b0};
      vectors++;
      if ({gnt0, gnt1, busy, sr_en, sr_in, done} !== exp_v) begin
        miscompares++;
        $display("FAIL shift_bit%0d got g0,g1,busy,en,in,done=%b want %b", i, {gnt0, gnt1, busy, sr_en, sr_in, done}, exp_v);
      end
    end
    @(negedge clk);
    vectors++;
    if ({gnt0, gnt1, busy, sr_en, sr_in, done} !== 6'b001000) begin
      miscompares++;
      $display("FAIL capture_cycle got g0,g1,busy,en,in,done=%b want 001000", {gnt0, gnt1, busy, sr_en, sr_in, done});
    end
    @(negedge clk);
    vectors++;
    if ({gnt0, gnt1, busy, sr_en, done, done_id, result} !== {5'b00001, id, word}) begin
      miscompares++;
      $display("FAIL done_cycle got g0,g1,busy,en,done,id,result=%b want %b",
               {gnt0, gnt1, busy, sr_en, done, done_id, result}, {5'b00001, id, word});
    end
  endtask

  task automatic check_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vectors++;
      if ({sr_en, gnt0, gnt1, done, busy} !== 5'b0) begin
        miscompares++;
        $display("FAIL %s cycle %0d got en,g0,g1,done,busy=%b want 00000", tag, i, {sr_en, gnt0, gnt1, done, busy});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({gnt0, gnt1, sr_en, sr_in, busy, done, done_id, result} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want all zero", {gnt0, gnt1, sr_en, sr_in, busy, done, done_id, result});
    end
    @(negedge clk);
    rst    = 1'b0;
    last_m = 1'b1;
    mon_en = 1'b1;
    check_quiet(10, "idle_after_reset");
  endtask

  task automatic test_single();
    int c;
    data0 = 4'b1011;
    req0  = 1'b1;
    last_m = pick(1'b1, 1'b0);
    wait_grant(c);
    req0 = 1'b0;
    vectors++;
    if (c !== 1) begin
      miscompares++;
      $display("FAIL single_latency got %0d want 1", c);
    end
    follow_xfer(1'b0, 4'b1011, 1'b0);
    check_quiet(2, "after_single");
  endtask

  task automatic test_simultaneous();
    int c;
    time t_done[2];
    @(negedge clk);
    rst = 1'b1;
    data0 = 4'b0110; data1 = 4'b1001;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_m = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bit w;
      w = pick(req0, req1);
      last_m = w;
      wait_grant(c);
      vectors++;
      if (c !== 1) begin
        miscompares++;
        $display("FAIL simul_latency%0d got %0d want 1", k, c);
      end
      if (w) req1 = 1'b0; else req0 = 1'b0;
      follow_xfer(w, w ? 4'b1001 : 4'b0110, 1'b0);
      t_done[k] = $time;
    end
    vectors++;
    if (t_done[1] - t_done[0] !== 60) begin
      miscompares++;
      $display("FAIL done_spacing got %0t want 60", t_done[1] - t_done[0]);
    end
  endtask

  task automatic test_fairness();
    int c;
    data0 = N'($urandom); data1 = N'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bit w;
      w = pick(1'b1, 1'b1);
      last_m = w;
      wait_grant(c);
      follow_xfer(w, w ? data1 : data0, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;
    check_quiet(2, "after_fairness");
  endtask

  task automatic test_late();
    int c;
    logic [N-1:0] d0, d1;
    d0 = N'($urandom); d1 = N'($urandom);
    data0 = d0; data1 = d1;
    req0 = 1'b1;
    last_m = pick(1'b1, 1'b0);
    wait_grant(c);
    req0 = 1'b0;
    follow_xfer(1'b0, d0, 1'b1);
    last_m = pick(1'b0, 1'b1);
    wait_grant(c);
    req1 = 1'b0;
    vectors++;
    if (c !== 1 || gnt0 !== 1'b0) begin
      miscompares++;
      $display("FAIL late_grant got latency=%0d gnt0=%b want 1 0", c, gnt0);
    end
    follow_xfer(1'b1, d1, 1'b0);
    check_quiet(4, "pulsed_req0_ignored");
  endtask

  task automatic test_reset_mid_shift();
    int c;
    logic [N-1:0] d0;
    d0 = N'($urandom);
    data0 = d0;
    req0 = 1'b1;
    last_m = pick(1'b1, 1'b0);
    wait_grant(c);
    req0 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({sr_en, busy, gnt0, gnt1, done} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_mid_shift got en,busy,g0,g1,done=%b want 00000", {sr_en, busy, gnt0, gnt1, done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_m = 1'b1;
    check_quiet(3, "no_done_after_abort");
    data0 = N'($urandom); data1 = 4'b1111;
    d0 = data0;
    req0 = 1'b1; req1 = 1'b1;
    begin
      bit w;
      w = pick(1'b1, 1'b1);
      last_m = w;
      wait_grant(c);
      if (w) req1 = 1'b0; else req0 = 1'b0;
      follow_xfer(w, w ? 4'b1111 : d0, 1'b0);
      w = pick(req0, req1);
      last_m = w;
      wait_grant(c);
      if (w) req1 = 1'b0; else req0 = 1'b0;
      follow_xfer(w, w ? 4'b1111 : d0, 1'b0);
    end
  endtask

  task automatic test_random();
    int c;
    for (int k = 0; k < 10; k++) begin
      bit w;
      logic [N-1:0] word;
      if (!req0 && $urandom_range(0, 1) == 1) begin data0 = N'($urandom); req0 = 1'b1; end
      if (!req1 && $urandom_range(0, 1) == 1) begin data1 = N'($urandom); req1 = 1'b1; end
      if (!req0 && !req1) begin data0 = N'($urandom); req0 = 1'b1; end
      w = pick(req0, req1);
      last_m = w;
      word = w ? data1 : data0;
      wait_grant(c);
      vectors++;
      if (c !== 1) begin
        miscompares++;
        $display("FAIL random%0d_latency got %0d want 1", k, c);
      end
      if (w) begin req1 = 1'b0; data1 = N'($urandom); end
      else   begin req0 = 1'b0; data0 = N'($urandom); end
      follow_xfer(w, word, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;
    check_quiet(3, "after_random");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no completion want finish before 100us");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_late();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
